hazard_scoreboard: RTL and testbench

//  Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.

---
 rtl/hazard_scoreboard_pkg.sv | 18 +
 rtl/hazard_scoreboard_if.sv | 44 ++++
 rtl/hazard_scoreboard_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared constants for the hazard/forwarding scoreboard.
//   FWD_RF          : fwd_sel code meaning "read the register file"
//   LAT_ALU/LAT_LOAD: id_lat codes, i.e. the first slot whose result can be
//                     forwarded (ALU results in EX, load data in MEM)
//   sel_width()     : width of the fwd_sel code for a given slot count
package hazard_scoreboard_pkg;

    localparam int FWD_RF   = 0;
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

    // fwd_sel has to encode 0 (RF) plus 1..nstage (slot k -> k+1)
    function automatic int sel_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_if
//   ID-stage request and hazard response bundle between the decode stage
//   (master) and the scoreboard (slave).
//   master -> slave : id_valid, id_rs1, id_rs1_use, id_rs2, id_rs2_use,
//                     id_rd, id_wen, id_lat, flush, perf_clr
//   slave -> master : stall, fwd_sel1, fwd_sel2, stall_cnt
interface hazard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RW     = 5,
    parameter int CW     = 16
) ();

    localparam int SW = sel_width(NSTAGE);

    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic          id_rs1_use;
    logic [RW-1:0] id_rs2;
    logic          id_rs2_use;
    logic [RW-1:0] id_rd;
    logic          id_wen;
    logic [SW-1:0] id_lat;
    logic          flush;
    logic          perf_clr;
    logic          stall;
    logic [SW-1:0] fwd_sel1;
    logic [SW-1:0] fwd_sel2;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs1_use, id_rs2, id_rs2_use,
               id_rd, id_wen, id_lat, flush, perf_clr,
        input  stall, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_use, id_rs2, id_rs2_use,
               id_rd, id_wen, id_lat, flush, perf_clr,
        output stall, fwd_sel1, fwd_sel2, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match
//   Youngest-writer priority encoder for one source operand.
//   r, src_use        : source register index and "operand is read" flag
//   slot_v/wen/rd/lat : in-flight writer slots, slot 0 = EX (youngest)
//   hit               : some valid writer targets r (x0 never matches)
//   k                 : index of the youngest matching slot
//   hit_lat           : forwarding latency recorded for that writer
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RW     = 5,
    parameter int SW     = sel_width(NSTAGE)
) (
    input  logic [RW-1:0]              r,
    input  logic                       src_use,
    input  logic [NSTAGE-1:0]          slot_v,
    input  logic [NSTAGE-1:0]          slot_wen,
    input  logic [NSTAGE-1:0][RW-1:0]  slot_rd,
    input  logic [NSTAGE-1:0][SW-1:0]  slot_lat,
    output logic                       hit,
    output logic [SW-1:0]              k,
    output logic [SW-1:0]              hit_lat
);

    // Walk from oldest to youngest so the lowest matching index is the last
    // one written and therefore wins.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        hit_lat = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (src_use && (r != '0) && slot_v[i] && slot_wen[i] &&
                (slot_rd[i] == r)) begin
                hit     = 1'b1;
                k       = SW'(i);
                hit_lat = slot_lat[i];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for the in-order pipeline. Tracks the
//   register writers in flight between EX and WB, decides whether the
//   instruction in ID has to stall and where each source operand comes from.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_if slave (ID request in, stall / fwd_sel / stall_cnt out)
//   FWD_EN=1 : forward from any slot once the writer's result exists
//   FWD_EN=0 : no bypass network; stall until the writer has left WB
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int RW     = 5,
    parameter int FWD_EN = 1,
    parameter int CW     = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  bus
);

    localparam int SW = sel_width(NSTAGE);

    // writer slots, index 0 = EX .. NSTAGE-1 = WB
    logic [NSTAGE-1:0]          vld_pipe;
    logic [NSTAGE-1:0]          slot_wen;
    logic [NSTAGE-1:0][RW-1:0]  slot_rd;
    logic [NSTAGE-1:0][SW-1:0]  slot_lat;

    logic [1:0][RW-1:0]         src_r;
    logic [1:0]                 src_use;
    logic [1:0]                 hit;
    logic [1:0][SW-1:0]         hit_k;
    logic [1:0][SW-1:0]         hit_lat;
    logic [1:0]                 hazard;
    logic [1:0][SW-1:0]         sel;

    logic                       stall;
    logic                       enter;
    logic [CW-1:0]              cnt;

    assign src_r[0]   = bus.id_rs1;
    assign src_r[1]   = bus.id_rs2;
    assign src_use[0] = bus.id_rs1_use;
    assign src_use[1] = bus.id_rs2_use;

    for (genvar g = 0; g < 2; g++) begin : g_src
        hazard_match #(
            .NSTAGE (NSTAGE),
            .RW     (RW),
            .SW     (SW)
        ) u_match (
            .r        (src_r[g]),
            .src_use  (src_use[g]),
            .slot_v   (vld_pipe),
            .slot_wen (slot_wen),
            .slot_rd  (slot_rd),
            .slot_lat (slot_lat),
            .hit      (hit[g]),
            .k        (hit_k[g]),
            .hit_lat  (hit_lat[g])
        );
    end

    // A writer still short of its result slot blocks; once there it is
    // bypassed as sel=k+1. Without forwarding every match blocks, including
    // the WB slot, because the RF is not written through.
    always_comb begin
        hazard = '0;
        sel    = '0;
        for (int g = 0; g < 2; g++) begin
            sel[g] = SW'(FWD_RF);
            if (hit[g]) begin
                if (FWD_EN != 0) begin
                    if (hit_k[g] < hit_lat[g]) hazard[g] = 1'b1;
                    else                       sel[g]    = hit_k[g] + SW'(1);
                end else begin
                    hazard[g] = 1'b1;
                end
            end
        end
    end

    assign stall = bus.id_valid & ~bus.flush & (|hazard);
    assign enter = bus.id_valid & ~stall & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            slot_wen <= '0;
            slot_rd  <= '0;
            slot_lat <= '0;
        end else begin
            for (int i = NSTAGE - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                slot_wen[i] <= slot_wen[i-1];
                slot_rd[i]  <= slot_rd[i-1];
                slot_lat[i] <= slot_lat[i-1];
            end
            vld_pipe[0] <= enter;
            slot_wen[0] <= enter & bus.id_wen;
            slot_rd[0]  <= bus.id_rd;
            slot_lat[0] <= bus.id_lat;
        end
    end

    // clear wins over the increment issued in the same cycle
    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr)           cnt <= '0;
        else if (stall && (cnt != '1))     cnt <= cnt + CW'(1);
    end

    assign bus.stall     = stall;
    assign bus.fwd_sel1  = sel[0];
    assign bus.fwd_sel2  = sel[1];
    assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NS = 3;
    localparam int RW = 5;
    localparam int CW = 16;

    localparam int K_STALL = 0;
    localparam int K_SEL1  = 1;
    localparam int K_SEL2  = 2;
    localparam int K_CNT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus1/dut1 forwards, bus0/dut0 has forwarding disabled; both get the
    // same stimulus
    hazard_if #(.NSTAGE(NS), .RW(RW), .CW(CW)) bus1 ();
    hazard_if #(.NSTAGE(NS), .RW(RW), .CW(CW)) bus0 ();

    hazard_scoreboard #(.NSTAGE(NS), .RW(RW), .FWD_EN(1), .CW(CW)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    hazard_scoreboard #(.NSTAGE(NS), .RW(RW), .FWD_EN(0), .CW(CW)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    typedef struct {
        int    cyc;
        bit    d;
        int    kind;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];

    task automatic want(input bit d, input int kind, input int val, input string name);
        exp_t e;
        e.cyc = cyc; e.d = d; e.kind = kind; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    function automatic int actual(input bit d, input int kind);
        case (kind)
            K_STALL: return d ? int'(bus1.stall)     : int'(bus0.stall);
            K_SEL1:  return d ? int'(bus1.fwd_sel1)  : int'(bus0.fwd_sel1);
            K_SEL2:  return d ? int'(bus1.fwd_sel2)  : int'(bus0.fwd_sel2);
            default: return d ? int'(bus1.stall_cnt) : int'(bus0.stall_cnt);
        endcase
    endfunction

    // monitor: compare every expectation registered for the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            int   a;
            e = q.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s dut%0d not sampled in its cycle", e.name, e.d);
            end else begin
                a = actual(e.d, e.kind);
                if (a != e.val) begin
                    errors++;
                    $display("FAIL %s dut%0d got %0d want %0d", e.name, e.d, a, e.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_drive(input logic v, input int rs1, input logic u1,
                            input int rs2, input logic u2, input int rd,
                            input logic wen, input int lat, input logic fl);
        bus1.id_valid = v;  bus0.id_valid = v;
        bus1.id_rs1 = RW'(rs1);  bus0.id_rs1 = RW'(rs1);
        bus1.id_rs1_use = u1;    bus0.id_rs1_use = u1;
        bus1.id_rs2 = RW'(rs2);  bus0.id_rs2 = RW'(rs2);
        bus1.id_rs2_use = u2;    bus0.id_rs2_use = u2;
        bus1.id_rd = RW'(rd);    bus0.id_rd = RW'(rd);
        bus1.id_wen = wen;       bus0.id_wen = wen;
        bus1.id_lat = 2'(lat);   bus0.id_lat = 2'(lat);
        bus1.flush = fl;         bus0.flush = fl;
    endtask

    task automatic set_clr(input logic c);
        bus1.perf_clr = c;
        bus0.perf_clr = c;
    endtask

    task automatic idle();
        id_drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input int rd, input int lat);
        id_drive(1, 0, 0, 0, 0, rd, 1, lat, 0);
    endtask

    // three empty cycles flush every writer out of the WB slot
    task automatic drain();
        repeat (NS) begin
            step();
            idle();
        end
    endtask

    initial begin
        idle();
        set_clr(1'b0);
        rst = 1'b1;
        repeat (3) step();

        // reset state
        step(); rst = 1'b0; idle();
        want(1, K_STALL, 0, "rst_stall");
        want(1, K_SEL1, 0, "rst_sel1");
        want(1, K_SEL2, 0, "rst_sel2");
        want(1, K_CNT, 0, "rst_cnt");
        want(0, K_CNT, 0, "rst_cnt0");

        // ALU result forwarded from EX
        step(); issue(5, LAT_ALU);
        want(1, K_STALL, 0, "t1_issue_stall");
        step(); id_drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        want(1, K_STALL, 0, "t1_stall");
        want(1, K_SEL1, 1, "t1_sel1");
        drain();

        // load-use: one bubble, then forward from MEM
        step(); issue(6, LAT_LOAD);
        step(); id_drive(1, 0, 0, 6, 1, 0, 0, 0, 0);
        want(1, K_STALL, 1, "t2_stall");
        want(1, K_SEL2, 0, "t2_sel2_hz");
        step();
        want(1, K_STALL, 0, "t2_release");
        want(1, K_SEL2, 2, "t2_sel2");
        want(1, K_CNT, 1, "t2_cnt");
        drain();

        // x0 writer and wen=0 writer never match
        step(); issue(0, LAT_ALU);
        step(); id_drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        want(1, K_STALL, 0, "t3_x0_stall");
        want(1, K_SEL1, 0, "t3_x0_sel1");
        step(); id_drive(1, 0, 0, 0, 0, 12, 0, 0, 0);
        step(); id_drive(1, 0, 0, 12, 1, 0, 0, 0, 0);
        want(1, K_STALL, 0, "t3_nowen_stall");
        want(1, K_SEL2, 0, "t3_nowen_sel2");
        drain();

        // flush beats a load-use stall and leaves a bubble in EX
        step(); issue(9, LAT_LOAD);
        step(); id_drive(1, 0, 0, 9, 1, 10, 1, LAT_LOAD, 1);
        want(1, K_STALL, 0, "t4_flush_stall");
        step(); id_drive(1, 10, 1, 9, 1, 0, 0, 0, 0);
        want(1, K_STALL, 0, "t4_bubble_stall");
        want(1, K_SEL1, 0, "t4_bubble_sel1");
        want(1, K_SEL2, 2, "t4_sel2");
        want(1, K_CNT, 1, "t4_cnt");
        drain();

        // two writers of x7: youngest wins
        step(); issue(7, LAT_ALU);
        step(); issue(7, LAT_ALU);
        step(); id_drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        want(1, K_STALL, 0, "t5_stall");
        want(1, K_SEL1, 1, "t5_sel1");
        drain();

        // young load shadows an older ready ALU writer
        step(); issue(11, LAT_ALU);
        step(); issue(11, LAT_LOAD);
        step(); id_drive(1, 11, 1, 0, 0, 0, 0, 0, 0);
        want(1, K_STALL, 1, "t5b_stall");
        want(1, K_SEL1, 0, "t5b_sel1_hz");
        step();
        want(1, K_STALL, 0, "t5b_release");
        want(1, K_SEL1, 2, "t5b_sel1");
        want(1, K_CNT, 2, "t5b_cnt");
        drain();

        // forward from the WB slot
        step(); issue(13, LAT_ALU);
        step(); idle();
        step(); idle();
        step(); id_drive(1, 13, 1, 0, 0, 0, 0, 0, 0);
        want(1, K_STALL, 0, "wb_stall");
        want(1, K_SEL1, 3, "wb_sel1");
        drain();

        // perf_clr during a stall cycle: clear wins
        step(); issue(14, LAT_LOAD);
        step(); id_drive(1, 14, 1, 0, 0, 0, 0, 0, 0); set_clr(1'b1);
        want(1, K_STALL, 1, "clr_stall");
        want(1, K_CNT, 2, "clr_cnt_before");
        step(); set_clr(1'b0);
        want(1, K_STALL, 0, "clr_release");
        want(1, K_SEL1, 2, "clr_sel1");
        want(1, K_CNT, 0, "clr_cnt");
        drain();

        // no-forwarding build stalls until the writer leaves WB
        step(); idle(); set_clr(1'b1);
        step(); set_clr(1'b0); issue(5, LAT_ALU);
        want(0, K_CNT, 0, "t6_cnt0");
        step(); id_drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        want(0, K_STALL, 1, "t6_nf_stall_a");
        want(0, K_SEL1, 0, "t6_nf_sel1_a");
        want(1, K_STALL, 0, "t6_f_stall");
        want(1, K_SEL1, 1, "t6_f_sel_ex");
        step();
        want(0, K_STALL, 1, "t6_nf_stall_b");
        want(1, K_SEL1, 2, "t6_f_sel_mem");
        step();
        want(0, K_STALL, 1, "t6_nf_stall_wb");
        want(1, K_SEL1, 3, "t6_f_sel_wb");
        step();
        want(0, K_STALL, 0, "t6_nf_release");
        want(0, K_SEL1, 0, "t6_nf_sel1");
        want(0, K_CNT, 3, "t6_nf_cnt");
        want(1, K_SEL1, 0, "t6_f_sel_gone");
        want(1, K_CNT, 0, "t6_f_cnt");
        drain();

        // reset mid-operation empties the slots
        step(); issue(15, LAT_ALU);
        step(); issue(15, LAT_ALU);
        step(); issue(15, LAT_ALU);
        step(); rst = 1'b1; idle();
        step(); rst = 1'b0; id_drive(1, 15, 1, 0, 0, 0, 0, 0, 0);
        want(1, K_STALL, 0, "t7_stall");
        want(1, K_SEL1, 0, "t7_sel1");
        want(1, K_CNT, 0, "t7_cnt");
        want(0, K_STALL, 0, "t7_nf_stall");
        want(0, K_CNT, 0, "t7_nf_cnt");
        step(); idle();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s dut%0d never compared", e.name, e.d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
